// File: rtl/read_logic_gen_pkg.sv
// Shared definitions for the tile BRAM read-side address generator.
package read_logic_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_e;

  localparam int RD_LATENCY_MAX     = 2;
  localparam int TILE_PTR_WIDTH_DEF = 9;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/read_logic_gen_tile_rd_fifo.sv
// Small synchronous FIFO that absorbs BRAM read latency; registered empty flag.
module tile_rd_fifo #(
  parameter int DEPTH      = 2,
  parameter int DATA_WIDTH = 64,
  parameter int CNT_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  empty,
  output logic [CNT_W-1:0]      count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CNT_W-1:0]      count_nxt;

  always_comb begin
    count_nxt = count + CNT_W'(push) - CNT_W'(pop);
  end

  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      count <= count_nxt;
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/read_logic_gen.sv
// Read-side tile address generator: issues credit-limited BRAM reads per tile
// and streams the returned words out through a valid/ready interface.
//
// state    | meaning
// ST_IDLE  | waiting for start_read; rejects it when no tile is available
// ST_ISSUE | issuing reads base+0 .. base+N-1 while FIFO credit allows
// ST_DRAIN | all reads issued, waiting for the last word to be popped
// ST_DONE  | one-cycle read_done, advance tile pointer
module read_logic_gen
  import read_logic_gen_pkg::*;
#(
  parameter int NUM_READS_PER_TILE = 2,
  parameter int ADDR_WIDTH         = 11,
  parameter int DATA_WIDTH         = 64,
  parameter int RD_LATENCY         = 1,
  parameter int TILE_PTR_WIDTH     = TILE_PTR_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tile_written,
  input  logic                      start_read,
  input  logic                      reset_addr_counter,
  output logic [ADDR_WIDTH-1:0]     bram_addr,
  output logic                      bram_en,
  input  logic [DATA_WIDTH-1:0]     bram_rdata,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      read_done,
  output logic                      read_underflow,
  output logic [TILE_PTR_WIDTH:0]   tiles_avail
);

  localparam int OFF_W      = cnt_width(NUM_READS_PER_TILE);
  localparam int FIFO_DEPTH = RD_LATENCY + 1;
  localparam int CNT_W      = cnt_width(RD_LATENCY_MAX + 1);
  localparam int SUM_W      = CNT_W + 1;
  localparam logic [ADDR_WIDTH-1:0] STRIDE   = ADDR_WIDTH'(NUM_READS_PER_TILE);
  localparam logic [OFF_W-1:0]      LAST_OFF = OFF_W'(NUM_READS_PER_TILE - 1);
  localparam logic [OFF_W-1:0]      N_OFF    = OFF_W'(NUM_READS_PER_TILE);

  rd_state_e                 state;
  logic [ADDR_WIDTH-1:0]     base;
  logic [OFF_W-1:0]          rd_offset;
  logic [OFF_W-1:0]          pop_cnt;
  logic [OFF_W-1:0]          pop_cnt_nxt;
  logic [TILE_PTR_WIDTH-1:0] tile_ptr;
  logic                      skip_inc;
  logic [RD_LATENCY-1:0]     vld_sr;
  logic [CNT_W-1:0]          inflight;
  logic [CNT_W-1:0]          fifo_count;
  logic                      fifo_empty;
  logic                      pop;
  logic                      issue;
  logic                      can_issue;
  logic                      final_pop;
  logic                      accept;
  logic                      avail_nz;

  assign pop         = out_valid && out_ready;
  assign out_valid   = !fifo_empty;
  assign avail_nz    = |tiles_avail;
  assign accept      = (state == ST_IDLE) && start_read && avail_nz;
  assign pop_cnt_nxt = pop_cnt + OFF_W'(pop);
  assign final_pop   = pop && (pop_cnt_nxt == N_OFF);

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CNT_W'(vld_sr[i]);
  end

  // A pop this cycle frees a slot, so it counts as credit for a new issue.
  assign can_issue = (SUM_W'(inflight) + SUM_W'(fifo_count)) <
                     (SUM_W'(RD_LATENCY + 1) + SUM_W'(pop));
  assign issue     = (state == ST_ISSUE) && can_issue;
  assign bram_en   = issue;
  assign bram_addr = issue ? base + ADDR_WIDTH'(rd_offset) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      base           <= '0;
      rd_offset      <= '0;
      pop_cnt        <= '0;
      tile_ptr       <= '0;
      skip_inc       <= 1'b0;
      read_done      <= 1'b0;
      read_underflow <= 1'b0;
    end else begin
      read_done      <= 1'b0;
      read_underflow <= 1'b0;
      if (pop) pop_cnt <= pop_cnt_nxt;
      case (state)
        ST_IDLE: begin
          if (start_read) begin
            if (avail_nz) begin
              state     <= ST_ISSUE;
              base      <= ADDR_WIDTH'(tile_ptr) * STRIDE;
              rd_offset <= '0;
              pop_cnt   <= '0;
            end else begin
              read_underflow <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (issue) begin
            rd_offset <= rd_offset + 1'b1;
            if (rd_offset == LAST_OFF) begin
              if (final_pop) begin
                state     <= ST_DONE;
                read_done <= 1'b1;
              end else begin
                state <= ST_DRAIN;
              end
            end
          end
        end
        ST_DRAIN: begin
          if (final_pop) begin
            state     <= ST_DONE;
            read_done <= 1'b1;
          end
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
      // A clear seen mid-tile must survive this tile's DONE increment.
      if (reset_addr_counter)    tile_ptr <= '0;
      else if (state == ST_DONE) tile_ptr <= skip_inc ? '0 : tile_ptr + 1'b1;
      if (state == ST_DONE) skip_inc <= 1'b0;
      else if (reset_addr_counter && (state == ST_ISSUE || state == ST_DRAIN)) skip_inc <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tiles_avail <= '0;
    end else if (tile_written && !accept) begin
      if (tiles_avail != '1) tiles_avail <= tiles_avail + 1'b1;
    end else if (accept && !tile_written) begin
      tiles_avail <= tiles_avail - 1'b1;
    end
  end

  generate
    if (RD_LATENCY == 1) begin : g_sr1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_sr <= '0;
        else        vld_sr <= issue;
      end
    end else begin : g_srn
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_sr <= '0;
        else        vld_sr <= {vld_sr[RD_LATENCY-2:0], issue};
      end
    end
  endgenerate

  tile_rd_fifo #(
    .DEPTH      (FIFO_DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (vld_sr[RD_LATENCY-1]),
    .push_data (bram_rdata),
    .pop       (pop),
    .pop_data  (out_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_read_logic_gen.sv
// Bench for read_logic_gen: default instance (a) and a small-width, latency-2 instance (b).
module tb_read_logic_gen;

  localparam int NA = 2, AWA = 11, LA = 1, TPWA = 9, DW = 64;
  localparam int NB = 4, AWB = 4,  LB = 2, TPWB = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  logic tile_written = 1'b0, start_read = 1'b0, rac = 1'b0, out_ready = 1'b1;

  logic            a_en, a_vld, a_done, a_under;
  logic [AWA-1:0]  a_addr;
  logic [DW-1:0]   a_rdata, a_data;
  logic [TPWA:0]   a_avail;
  logic            b_en, b_vld, b_done, b_under;
  logic [AWB-1:0]  b_addr;
  logic [DW-1:0]   b_rdata, b_p0, b_data;
  logic [TPWB:0]   b_avail;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  function automatic logic [63:0] wdat(input int unsigned addr);
    return {32'hCAFE_0000 + addr, 32'h1234_5678 ^ addr};
  endfunction

  always @(posedge clk) a_rdata <= wdat(32'(a_addr));
  always @(posedge clk) begin
    b_p0    <= wdat(32'(b_addr));
    b_rdata <= b_p0;
  end

  read_logic_gen #(.NUM_READS_PER_TILE(NA), .ADDR_WIDTH(AWA), .DATA_WIDTH(DW),
                   .RD_LATENCY(LA), .TILE_PTR_WIDTH(TPWA)) dut_a (
    .clk(clk), .rst_n(rst_n), .tile_written(tile_written), .start_read(start_read),
    .reset_addr_counter(rac), .bram_addr(a_addr), .bram_en(a_en), .bram_rdata(a_rdata),
    .out_data(a_data), .out_valid(a_vld), .out_ready(out_ready), .read_done(a_done),
    .read_underflow(a_under), .tiles_avail(a_avail));

  read_logic_gen #(.NUM_READS_PER_TILE(NB), .ADDR_WIDTH(AWB), .DATA_WIDTH(DW),
                   .RD_LATENCY(LB), .TILE_PTR_WIDTH(TPWB)) dut_b (
    .clk(clk), .rst_n(rst_n), .tile_written(tile_written), .start_read(start_read),
    .reset_addr_counter(rac), .bram_addr(b_addr), .bram_en(b_en), .bram_rdata(b_rdata),
    .out_data(b_data), .out_valid(b_vld), .out_ready(out_ready), .read_done(b_done),
    .read_underflow(b_under), .tiles_avail(b_avail));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    tile_written = 0; start_read = 0; rac = 0; out_ready = 1;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic pulse_tiles(input int n);
    tile_written = 1;
    repeat (n) @(posedge clk);
    #1 tile_written = 0;
  endtask

  // Runs one tile on instance a with out_ready=1; start_read is cycle 0.
  task automatic run_tile_a(input int rac_cyc, output int n_iss, output int ad0,
                            output int ad1, output int done_cyc);
    n_iss = 0; ad0 = -1; ad1 = -1; done_cyc = -1;
    start_read = 1; out_ready = 1;
    for (int c = 0; c < 30; c++) begin
      rac = (c == rac_cyc);
      @(negedge clk);
      if (a_en) begin
        if (n_iss == 0) ad0 = int'(a_addr); else ad1 = int'(a_addr);
        n_iss++;
      end
      if (a_done) done_cyc = c;
      @(posedge clk);
      #1 start_read = 0; rac = 0;
      if (done_cyc >= 0) break;
    end
  endtask

  typedef struct {
    bit tw, sr, rdy;
    bit en; int addr; bit vld; int daddr; bit done; bit under; int avail;
  } vec_t;
  vec_t tbl[17];

  // random-test reference model state (instance b)
  int  m_avail, m_ptr, m_base, m_issued, m_popped, m_acc, n_done;
  bit  m_busy, m_pend, m_done_now, m_under_now, prev_hold;
  logic [DW-1:0] prev_data;
  int  q[$];

  initial begin
    int n_iss, ad0, ad1, dc, cnt, idx;
    bit pop, next_done, idle, accept, next_under;

    // reset values
    @(negedge clk);
    chk("rst_en", a_en, 0);      chk("rst_addr", a_addr, 0);
    chk("rst_valid", a_vld, 0);  chk("rst_data", a_data, 0);
    chk("rst_done", a_done, 0);  chk("rst_under", a_under, 0);
    chk("rst_avail", a_avail, 0); chk("rst_b_valid", b_vld, 0);
    @(posedge clk);
    #1 rst_n = 1;

    // basic tile, underflow, simultaneous write+start, second tile at base 2
    tbl[0]  = '{1,0,1, 0,0, 0,0, 0,0, 0};
    tbl[1]  = '{0,0,1, 0,0, 0,0, 0,0, 1};
    tbl[2]  = '{0,1,1, 0,0, 0,0, 0,0, 1};
    tbl[3]  = '{0,0,1, 1,0, 0,0, 0,0, 0};
    tbl[4]  = '{0,0,1, 1,1, 0,0, 0,0, 0};
    tbl[5]  = '{0,0,1, 0,0, 1,0, 0,0, 0};
    tbl[6]  = '{0,0,1, 0,0, 1,1, 0,0, 0};
    tbl[7]  = '{0,0,1, 0,0, 0,0, 1,0, 0};
    tbl[8]  = '{0,1,1, 0,0, 0,0, 0,0, 0};
    tbl[9]  = '{0,0,1, 0,0, 0,0, 0,1, 0};
    tbl[10] = '{1,0,1, 0,0, 0,0, 0,0, 0};
    tbl[11] = '{1,1,1, 0,0, 0,0, 0,0, 1};
    tbl[12] = '{0,0,1, 1,2, 0,0, 0,0, 1};
    tbl[13] = '{0,0,1, 1,3, 0,0, 0,0, 1};
    tbl[14] = '{0,0,1, 0,0, 1,2, 0,0, 1};
    tbl[15] = '{0,0,1, 0,0, 1,3, 0,0, 1};
    tbl[16] = '{0,0,1, 0,0, 0,0, 1,0, 1};
    for (int k = 0; k < 17; k++) begin
      tile_written = tbl[k].tw; start_read = tbl[k].sr; out_ready = tbl[k].rdy;
      @(negedge clk);
      chk($sformatf("v%0d_en", k), a_en, tbl[k].en);
      chk($sformatf("v%0d_addr", k), a_addr, tbl[k].addr);
      chk($sformatf("v%0d_valid", k), a_vld, tbl[k].vld);
      if (tbl[k].vld) chk($sformatf("v%0d_data", k), a_data, wdat(tbl[k].daddr));
      chk($sformatf("v%0d_done", k), a_done, tbl[k].done);
      chk($sformatf("v%0d_under", k), a_under, tbl[k].under);
      chk($sformatf("v%0d_avail", k), a_avail, tbl[k].avail);
      @(posedge clk);
      #1;
    end
    tile_written = 0; start_read = 0;

    // tile pointer clear mid-tile and coinciding with DONE
    do_reset();
    pulse_tiles(7);
    for (int t = 0; t < 3; t++) begin
      run_tile_a(-1, n_iss, ad0, ad1, dc);
      chk($sformatf("ptr_t%0d_a0", t), ad0, 2 * t);
      chk($sformatf("ptr_t%0d_a1", t), ad1, 2 * t + 1);
    end
    run_tile_a(1, n_iss, ad0, ad1, dc);
    chk("rac_mid_a0", ad0, 6); chk("rac_mid_a1", ad1, 7); chk("rac_mid_done_cyc", dc, 5);
    run_tile_a(-1, n_iss, ad0, ad1, dc);
    chk("after_mid_a0", ad0, 0); chk("after_mid_a1", ad1, 1);
    run_tile_a(5, n_iss, ad0, ad1, dc);
    chk("rac_done_a0", ad0, 2); chk("rac_done_cyc", dc, 5);
    run_tile_a(-1, n_iss, ad0, ad1, dc);
    chk("after_done_a0", ad0, 0); chk("after_done_a1", ad1, 1); chk("after_done_n", n_iss, 2);

    // backpressure on latency-2 instance: credit limits to 3 reads
    do_reset();
    pulse_tiles(1);
    start_read = 1; out_ready = 0; cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (b_en) cnt++;
      @(posedge clk);
      #1 start_read = 0;
    end
    chk("stall_issue_cnt", cnt, 3);
    out_ready = 1; idx = 0; dc = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (b_vld) begin
        chk($sformatf("stall_word%0d", idx), b_data, wdat(idx));
        idx++;
      end
      if (b_done) dc = c;
      @(posedge clk);
      #1;
      if (dc >= 0) break;
    end
    chk("stall_word_cnt", idx, NB);
    chk("stall_done_seen", dc >= 0, 1);

    // async reset while a word is pending in DRAIN
    do_reset();
    pulse_tiles(1);
    start_read = 1; out_ready = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 3) chk("drain_pending_valid", a_vld, 1);
      @(posedge clk);
      #1 start_read = 0;
    end
    #2 rst_n = 0;
    #1;
    chk("arst_valid", a_vld, 0); chk("arst_en", a_en, 0); chk("arst_avail", a_avail, 0);
    @(posedge clk);
    #1 rst_n = 1; out_ready = 1;
    pulse_tiles(1);
    run_tile_a(-1, n_iss, ad0, ad1, dc);
    chk("arst_fresh_a0", ad0, 0); chk("arst_fresh_a1", ad1, 1); chk("arst_fresh_done", dc, 5);

    // randomized run on instance b against the tile-level model
    do_reset();
    m_avail = 0; m_ptr = 0; m_base = 0; m_issued = 0; m_popped = 0; m_acc = 0; n_done = 0;
    m_busy = 0; m_pend = 0; m_done_now = 0; m_under_now = 0; prev_hold = 0; prev_data = '0;
    q.delete();
    for (int cyc = 0; cyc < 3080; cyc++) begin
      if (cyc < 3000) begin
        tile_written = ($urandom_range(0, 99) < 30);
        start_read   = ($urandom_range(0, 99) < 25);
        rac          = ($urandom_range(0, 99) < 4);
        out_ready    = ($urandom_range(0, 99) < 65);
      end else begin
        tile_written = 0; start_read = 0; rac = 0; out_ready = 1;
      end
      @(negedge clk);
      pop = b_vld && out_ready;
      chk("rnd_avail", b_avail, m_avail);
      chk("rnd_done", b_done, m_done_now);
      chk("rnd_under", b_under, m_under_now);
      if (b_en) begin
        chk("rnd_en_legal", m_busy && (m_issued < NB), 1);
        chk("rnd_addr", b_addr, (m_base + m_issued) % 16);
        chk("rnd_credit", (m_issued - m_popped - int'(pop)) <= LB, 1);
        q.push_back((m_base + m_issued) % 16);
        m_issued++;
      end else begin
        chk("rnd_addr_idle", b_addr, 0);
      end
      if (prev_hold) begin
        chk("rnd_hold_valid", b_vld, 1);
        chk("rnd_hold_data", b_data, prev_data);
      end
      if (pop) begin
        chk("rnd_pop_expected", q.size() > 0, 1);
        if (q.size() > 0) chk("rnd_data", b_data, wdat(q.pop_front()));
        m_popped++;
      end
      prev_hold = b_vld && !out_ready;
      prev_data = b_data;
      if (b_done) n_done++;
      next_done  = m_busy && pop && (m_popped == NB);
      idle       = !m_busy && !m_done_now;
      accept     = idle && start_read && (m_avail > 0);
      next_under = idle && start_read && (m_avail == 0);
      if (accept) begin
        m_base = (m_ptr * NB) % 16;
        m_busy = 1; m_issued = 0; m_popped = 0; m_acc++;
      end
      if (m_done_now) begin
        m_ptr  = (rac || m_pend) ? 0 : (m_ptr + 1) % 8;
        m_pend = 0;
      end else if (rac) begin
        if (m_busy && !accept) m_pend = 1;
        m_ptr = 0;
      end
      if (tile_written && !accept) begin
        if (m_avail < 15) m_avail++;
      end else if (accept && !tile_written) begin
        m_avail--;
      end
      if (next_done) m_busy = 0;
      m_done_now  = next_done;
      m_under_now = next_under;
      @(posedge clk);
      #1;
    end
    chk("rnd_tiles_completed", n_done, m_acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
